freq_to_voltage: RTL and testbench
==================================

FREQ_TO_VOLTAGE -- requirements
Module: freq_to_voltage

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 50000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter F_FULL_HZ, default 4000, meaning the input frequency mapped to full scale 32767.
REQ-003 SHALL have parameter F_MIN_HZ, default 20, meaning the lowest frequency tracked; slower inputs time out.
REQ-004 SHALL have parameter HI_TH, default 16384, meaning the comparator rising threshold.
REQ-005 SHALL have parameter LO_TH, default 8192, meaning the comparator falling threshold.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port audio_clk_en, input, 1 bit: audio sample strobe, one clk wide.
REQ-009 SHALL have port in, input, signed 16 bits: audio-rate square-ish wave, e.g. a 555 oscillator output.
REQ-010 SHALL have port out, output, signed 16 bits: control voltage proportional to input frequency, 0..32767.
REQ-011 SHALL have port valid, output, 1 bit: one-clk pulse when a new measurement is written.
REQ-012 SHALL have port locked, output, 1 bit: high while consecutive rising edges arrive within the timeout.

Function
REQ-013 SHALL sample in only on audio_clk_en; comparator goes high when in >= HI_TH and low when in < LO_TH, otherwise holds.
REQ-014 SHALL detect a rising edge on the audio_clk_en cycle where the comparator goes from low to high.
REQ-015 SHALL count clk cycles in a 32-bit period counter that restarts at 1 on the cycle after each rising edge.
REQ-016 SHALL run FSM states WAIT_FIRST (no reference edge yet), MEASURE (counting), DIVIDE (divider busy); first edge: WAIT_FIRST->MEASURE; later edge: capture period, ->DIVIDE; divider done: ->MEASURE.
REQ-017 SHALL compute target = K / period, unsigned, with K = CLOCK_RATE*32767/F_FULL_HZ (truncated), result saturated to 32767.
REQ-018 SHALL use a 32-cycle sequential divider; out, valid and locked=1 SHALL update 34 clk after the edge cycle.
REQ-019 SHALL keep counting during DIVIDE; an edge arriving in DIVIDE SHALL be held in a one-deep pending register, last edge wins, and SHALL be divided immediately after the current division.
REQ-020 SHALL time out when the period counter reaches TIMEOUT = CLOCK_RATE/F_MIN_HZ: out=0, locked=0, valid pulses, state ->WAIT_FIRST, pending cleared.
REQ-021 SHALL let timeout take priority over an edge detected on the same cycle.

Reset
REQ-022 SHALL, when reset_n is low on a clk edge, set out=0, valid=0, locked=0, comparator=low, counter=0, pending=0, divider idle, state=WAIT_FIRST.
REQ-023 SHALL abort any division when reset occurs mid-operation and write no result.

Configuration
REQ-024 SHALL define macro FREQ_TO_VOLTAGE_SMOOTH_EN. When it is defined, out SHALL move by (target-out)>>>3 (arithmetic shift) on each audio_clk_en, like an RC filter, and timeout SHALL set target=0. When it is undefined, out SHALL equal target when written. valid timing SHALL be the same in both cases.

Structure
REQ-025 SHALL place the following in package freq_to_voltage_pkg: the FSM state enum, the counter width (32), full scale (32767), and a function computing K and TIMEOUT.
REQ-026 SHALL place the sequential divider in sub-module unsigned_divider_32, with start/done and dividend/divisor/quotient ports.

Verification (CLOCK_RATE=50e6, audio_clk_en every 1000 clk, smoothing off)
REQ-027 SHALL cover: 1 kHz input (0/32767 square) -> out=8191 from the second rising edge onward, locked=1.
REQ-028 SHALL cover: 4 kHz input -> out=32767; 8 kHz input -> out=32767 (saturated).
REQ-029 SHALL cover: 1 kHz input, then held at 0 -> 2,500,000 clk after the last counter restart, out=0, locked=0, valid pulses once.
REQ-030 SHALL cover: input oscillating between 10000 and 15000 -> no edges, out stays 0, valid never pulses.
REQ-031 SHALL cover: reset_n low for 1 clk 10 clk after an edge in DIVIDE -> no valid, out=0, next edge only re-arms (WAIT_FIRST->MEASURE).
REQ-032 SHALL cover: with FREQ_TO_VOLTAGE_SMOOTH_EN, a step from 0 to 1 kHz -> out rises monotonically and settles within 8 of 8191 after 60 audio_clk_en.

Source files
------------

// File: rtl/freq_to_voltage_pkg.sv
// ============================================================================
// Module : freq_to_voltage_pkg
// Brief  : Shared FSM state type, widths and scale constants for freq_to_voltage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package freq_to_voltage_pkg;

   localparam int c_cnt_w      = 32;
   localparam int c_full_scale = 32767;

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'd0,
      MEASURE    = 2'd1,
      DIVIDE     = 2'd2
   } state_t;

   // sel=0: K = clock_rate*full_scale/f_hz ; sel=1: TIMEOUT = clock_rate/f_hz
   function automatic logic [c_cnt_w-1:0] calc_scale_const(input int clock_rate,
                                                           input int f_hz,
                                                           input logic sel);
      logic [63:0] v;
      if (sel)
         v = 64'(clock_rate) / 64'(f_hz);
      else
         v = (64'(clock_rate) * 64'(c_full_scale)) / 64'(f_hz);
      return v[c_cnt_w-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/freq_to_voltage_divider.sv
// ============================================================================
// Module : unsigned_divider_32
// Brief  : 32-cycle restoring divider; done pulses one clk after the last step.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unsigned_divider_32 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic        done
);

   logic        r_busy;
   logic [4:0]  r_step;
   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_div;
   logic        r_done;
   logic [32:0] w_shift;
   logic [32:0] w_diff;

   // Bit 32 of the difference is the borrow: set when the shifted remainder < divisor
   assign w_shift = {r_rem, r_quo[31]};
   assign w_diff  = w_shift - {1'b0, r_div};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_busy <= 1'b0;
         r_step <= 5'd0;
         r_rem  <= 32'd0;
         r_quo  <= 32'd0;
         r_div  <= 32'd0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_busy <= 1'b1;
            r_step <= 5'd0;
            r_rem  <= 32'd0;
            r_quo  <= dividend;
            r_div  <= divisor;
         end else if (r_busy) begin
            if (!w_diff[32]) begin
               r_rem <= w_diff[31:0];
               r_quo <= {r_quo[30:0], 1'b1};
            end else begin
               r_rem <= w_shift[31:0];
               r_quo <= {r_quo[30:0], 1'b0};
            end
            r_step <= r_step + 5'd1;
            if (r_step == 5'd31) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign quotient = r_quo;
   assign done     = r_done;

endmodule

`default_nettype wire

// File: rtl/freq_to_voltage.sv
// ============================================================================
// Module : freq_to_voltage
// Brief  : Measures the period of a square-ish audio wave and outputs a CV
//          proportional to its frequency. Optional FREQ_TO_VOLTAGE_SMOOTH_EN
//          adds a first-order slew of out toward the measured target.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_to_voltage #(
   parameter int CLOCK_RATE = 50000000,
   parameter int F_FULL_HZ  = 4000,
   parameter int F_MIN_HZ   = 20,
   parameter int HI_TH      = 16384,
   parameter int LO_TH      = 8192
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               audio_clk_en,
   input  logic signed [15:0] in,
   output logic signed [15:0] out,
   output logic               valid,
   output logic               locked
);

   import freq_to_voltage_pkg::*;

   localparam logic [c_cnt_w-1:0] c_k       = calc_scale_const(CLOCK_RATE, F_FULL_HZ, 1'b0);
   localparam logic [c_cnt_w-1:0] c_timeout = calc_scale_const(CLOCK_RATE, F_MIN_HZ, 1'b1);
   localparam logic signed [15:0] c_hi      = 16'(HI_TH);
   localparam logic signed [15:0] c_lo      = 16'(LO_TH);

   state_t               r_state;
   logic                 r_cmp;
   logic [c_cnt_w-1:0]   r_count;
   logic [c_cnt_w-1:0]   r_period;
   logic [c_cnt_w-1:0]   r_pend_period;
   logic                 r_pend;
   logic                 r_start;
   logic signed [15:0]   r_out;
   logic                 r_valid;
   logic                 r_locked;
   logic [31:0]          w_quotient;
   logic                 w_done;
   logic                 w_edge;
   logic                 w_active;
   logic                 w_timeout;
   logic signed [15:0]   w_sat;
`ifdef FREQ_TO_VOLTAGE_SMOOTH_EN
   logic signed [15:0]   r_target;
   logic signed [16:0]   w_delta;
   logic signed [16:0]   w_step;
`endif

   assign w_edge    = audio_clk_en && !r_cmp && (in >= c_hi);
   assign w_active  = (r_state != WAIT_FIRST);
   assign w_timeout = w_active && (r_count == c_timeout);
   assign w_sat     = (w_quotient > 32'(c_full_scale)) ? 16'(c_full_scale) : w_quotient[15:0];

`ifdef FREQ_TO_VOLTAGE_SMOOTH_EN
   assign w_delta = {r_target[15], r_target} - {r_out[15], r_out};
   assign w_step  = w_delta >>> 3;
`endif

   unsigned_divider_32 u_div (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (r_start),
      .dividend (c_k),
      .divisor  (r_period),
      .quotient (w_quotient),
      .done     (w_done)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state       <= WAIT_FIRST;
         r_cmp         <= 1'b0;
         r_count       <= '0;
         r_period      <= '0;
         r_pend_period <= '0;
         r_pend        <= 1'b0;
         r_start       <= 1'b0;
         r_out         <= 16'sd0;
         r_valid       <= 1'b0;
         r_locked      <= 1'b0;
`ifdef FREQ_TO_VOLTAGE_SMOOTH_EN
         r_target      <= 16'sd0;
`endif
      end else begin
         r_valid <= 1'b0;
         r_start <= 1'b0;
         if (audio_clk_en) begin
            if (in >= c_hi)
               r_cmp <= 1'b1;
            else if (in < c_lo)
               r_cmp <= 1'b0;
         end
         // Timeout wins over an edge seen on the same cycle
         if (w_timeout) begin
            r_state  <= WAIT_FIRST;
            r_count  <= '0;
            r_pend   <= 1'b0;
            r_locked <= 1'b0;
            r_valid  <= 1'b1;
`ifdef FREQ_TO_VOLTAGE_SMOOTH_EN
            r_target <= 16'sd0;
`else
            r_out    <= 16'sd0;
`endif
         end else begin
            if (w_edge)
               r_count <= c_cnt_w'(1);
            else if (w_active)
               r_count <= r_count + c_cnt_w'(1);
            case (r_state)
               WAIT_FIRST: begin
                  if (w_edge)
                     r_state <= MEASURE;
               end
               MEASURE: begin
                  if (w_edge) begin
                     r_period <= r_count;
                     r_start  <= 1'b1;
                     r_state  <= DIVIDE;
                  end
               end
               DIVIDE: begin
                  if (w_done) begin
`ifdef FREQ_TO_VOLTAGE_SMOOTH_EN
                     r_target <= w_sat;
`else
                     r_out    <= w_sat;
`endif
                     r_valid  <= 1'b1;
                     r_locked <= 1'b1;
                     if (w_edge) begin
                        r_period <= r_count;
                        r_start  <= 1'b1;
                        r_pend   <= 1'b0;
                     end else if (r_pend) begin
                        r_period <= r_pend_period;
                        r_start  <= 1'b1;
                        r_pend   <= 1'b0;
                     end else begin
                        r_state  <= MEASURE;
                     end
                  end else if (w_edge) begin
                     r_pend        <= 1'b1;
                     r_pend_period <= r_count;
                  end
               end
               default: r_state <= WAIT_FIRST;
            endcase
         end
`ifdef FREQ_TO_VOLTAGE_SMOOTH_EN
         if (audio_clk_en)
            r_out <= r_out + w_step[15:0];
`endif
      end
   end

   assign out    = r_out;
   assign valid  = r_valid;
   assign locked = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_freq_to_voltage.sv
// ============================================================================
// Module : tb_freq_to_voltage
// Brief  : Scoreboard bench for freq_to_voltage; clock scaled to 1 MHz with a
//          50 kHz audio strobe so timeouts fit a short run.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_freq_to_voltage;

   localparam int     c_clock_rate = 1000000;
   localparam int     c_f_full     = 4000;
   localparam int     c_f_min      = 200;
   localparam int     c_hi         = 16384;
   localparam int     c_lo         = 8192;
   localparam int     c_strobe     = 20;
   localparam longint c_tclk       = 10;
   localparam longint c_k          = longint'(c_clock_rate) * 32767 / c_f_full;
   localparam longint c_tmo        = c_clock_rate / c_f_min;

   typedef struct {
      longint t;
      longint o;
      longint l;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               audio_clk_en = 1'b0;
   logic signed [15:0] in_s = 16'sd0;
   logic signed [15:0] out_s;
   logic               valid;
   logic               locked;

   exp_t   sb[$];
   int     checks = 0;
   int     failures = 0;
   bit     m_cmp = 1'b0;
   bit     m_armed = 1'b0;
   longint m_last = 0;

   freq_to_voltage #(
      .CLOCK_RATE (c_clock_rate),
      .F_FULL_HZ  (c_f_full),
      .F_MIN_HZ   (c_f_min),
      .HI_TH      (c_hi),
      .LO_TH      (c_lo)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .audio_clk_en (audio_clk_en),
      .in           (in_s),
      .out          (out_s),
      .valid        (valid),
      .locked       (locked)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Model: a timeout fires TIMEOUT clk after the last counter restart
   task automatic expire(input longint tp);
      if (m_armed && tp >= m_last + c_tmo * c_tclk) begin
         sb.push_back('{t: m_last + c_tmo * c_tclk + 5, o: 0, l: 1});
         sb[sb.size()-1].l = 0;
         m_armed = 1'b0;
      end
   endtask

   task automatic model_edge(input longint t);
      longint q;
      if (m_armed) begin
         q = c_k / ((t - m_last) / c_tclk);
         if (q > 32767) q = 32767;
         sb.push_back('{t: t + 34 * c_tclk + 5, o: q, l: 1});
      end
      m_armed = 1'b1;
      m_last  = t;
   endtask

   task automatic put(input logic signed [15:0] v);
      longint t;
      bit     hi;
      in_s = v;
      repeat (c_strobe - 1) @(posedge clk);
      #1 audio_clk_en = 1'b1;
      @(posedge clk);
      t = $time;
      #1 audio_clk_en = 1'b0;
      expire(t);
      hi = (v >= c_hi) ? 1'b1 : ((v < c_lo) ? 1'b0 : m_cmp);
      if (!m_cmp && hi) model_edge(t);
      m_cmp = hi;
   endtask

   task automatic tone(input int half, input int periods);
      for (int p = 0; p < periods; p++)
         for (int i = 0; i < 2 * half; i++)
            put((i < half) ? 16'sd32767 : 16'sd0);
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) put(16'sd0);
   endtask

   task automatic do_reset(input int cycles);
      reset_n = 1'b0;
      repeat (cycles) @(posedge clk);
      #1 reset_n = 1'b1;
      m_cmp   = 1'b0;
      m_armed = 1'b0;
      while (sb.size() > 0 && sb[sb.size()-1].t > $time) void'(sb.pop_back());
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (valid === 1'b1) begin
            expire($time - 5);
            if (sb.size() == 0) begin
               check("unexpected_valid", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("valid_time", $time, e.t);
`ifndef FREQ_TO_VOLTAGE_SMOOTH_EN
               check("out", out_s, e.o);
`endif
               check("locked", {63'd0, locked}, e.l);
            end
         end
      end
   end

   initial begin : watchdog
      #(100000 * c_tclk);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      logic signed [15:0] prev;
      do_reset(5);
      check("rst_out", out_s, 0);
      check("rst_valid", {63'd0, valid}, 0);
      check("rst_locked", {63'd0, locked}, 0);

      // Values inside the hysteresis band never produce an edge
      for (int i = 0; i < 60; i++) put((i % 2) ? 16'sd15000 : 16'sd10000);
      check("hyst_out", out_s, 0);
      check("hyst_locked", {63'd0, locked}, 0);

      // Threshold boundaries: 16384 sets, 8192 holds, 8191 clears
      put(16'sd0);
      put(16'sd16384);
      put(16'sd8192);
      put(16'sd16384);
      put(16'sd8191);
      hold(10);
      put(16'sd16384);
      hold(3);

      tone(25, 5);
      hold(300);
      check("tmo_out", out_s, 0);
      check("tmo_locked", {63'd0, locked}, 0);

      tone(6, 6);
      tone(3, 6);
      tone(25, 3);

      // Reset 10 clk after an edge, while the division is in flight
      put(16'sd32767);
      repeat (9) @(posedge clk);
      #1;
      do_reset(1);
      check("abort_out", out_s, 0);
      check("abort_locked", {63'd0, locked}, 0);
      check("abort_valid", {63'd0, valid}, 0);
      for (int i = 0; i < 24; i++) put(16'sd32767);
      hold(25);
      tone(25, 2);

`ifdef FREQ_TO_VOLTAGE_SMOOTH_EN
      do_reset(2);
      prev = out_s;
      for (int i = 0; i < 171; i++) begin
         put(((i % 50) < 25) ? 16'sd32767 : 16'sd0);
         check("smooth_mono", {63'd0, (out_s >= prev)}, 1);
         prev = out_s;
         if (i == 111)
            check("smooth_settle", {63'd0, (out_s >= 16'sd8183 && out_s <= 16'sd8199)}, 1);
      end
`endif

      hold(300);
      expire($time);
      repeat (10) @(posedge clk);
      #1;
      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
